serial_subtractor: RTL and testbench

//  Bit-serial, LSB-first unsigned WIDTH-bit subtractor: DIFF = A - B, with borrow-out.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 36 +++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_subtractor_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done operand bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B,
`ifdef SERIAL_SUB_OVF_EN
    input  ovf,
`endif
    input  diff, borrow, busy, done
  );

  modport slave (
    input  start, A, B,
`ifdef SERIAL_SUB_OVF_EN
    output ovf,
`endif
    output diff, borrow, busy, done
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell reused once per cycle by the serial datapath.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor (diff = A - B, borrow = A < B) with start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow flag (ovf).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; previous result held
// ST_SHIFT | one bit per cycle through the cell, busy=1, WIDTH cycles
// ST_DONE  | done pulse; start here begins the next operation directly
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_sr_nxt;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    count;
  logic             bin;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic cell_d;
  logic cell_bout;
  logic accept;
  logic step;
  logic finish;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bin),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        step = 1'b1;
        if (count == LAST_BIT) begin
          finish    = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The newest difference bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
  assign diff_sr_nxt = {cell_d, {(WIDTH-1){1'b0}}} | (diff_sr >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      diff_q   <= '0;
      count    <= '0;
      bin      <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        a_sr    <= bus.A;
        b_sr    <= bus.B;
        diff_sr <= '0;
        bin     <= 1'b0;
        count   <= '0;
        busy_q  <= 1'b1;
      end else if (step) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        diff_sr <= diff_sr_nxt;
        bin     <= cell_bout;
        if (!finish) count <= count + CW'(1);
      end
      if (finish) begin
        diff_q   <= diff_sr_nxt;
        borrow_q <= cell_bout;
        busy_q   <= 1'b0;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are shifted out during SHIFT, so they are kept separately.
  logic a_msb;
  logic b_msb;
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= bus.A[WIDTH-1];
        b_msb <= bus.B[WIDTH-1];
      end
      if (finish) ovf_q <= (a_msb != b_msb) && (cell_d != a_msb);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH=8 and WIDTH=2 against an arithmetic reference model.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(2)) bus2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst),  .bus(bus8.slave));
  serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));

  function automatic int ref_diff(input int a, input int b, input int w);
    int d;
    d = a - b;
    if (d < 0) d = d + (1 << w);
    return d;
  endfunction

  function automatic logic ref_borrow(input int a, input int b);
    return a < b;
  endfunction

`ifdef SERIAL_SUB_OVF_EN
  function automatic logic ref_ovf(input int a, input int b, input int w);
    int m, sa, sb, sd;
    m  = 1 << w;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sd = sa - sb;
    return (sd < -(m / 2)) || (sd >= m / 2);
  endfunction
`endif

  task automatic run_op8(input int a, input int b, output int d, output logic br,
                         output logic ov, output int lat, output int busy_cnt);
    @(negedge clk);
    bus8.A = 8'(a); bus8.B = 8'(b); bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = -1; busy_cnt = 0; d = 0; br = 1'b0; ov = 1'b0;
    for (int n = 1; n < 40; n++) begin
      if (bus8.busy) busy_cnt++;
      if (bus8.done) begin
        lat = n; d = int'(bus8.diff); br = bus8.borrow;
`ifdef SERIAL_SUB_OVF_EN
        ov = bus8.ovf;
`endif
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0;
    bus2.start = 1'b0; bus2.A = '0; bus2.B = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus8.diff !== 8'd0)  begin failures++; $display("FAIL reset_diff: got %0d expected 0", bus8.diff); end
    checks++; if (bus8.borrow !== 1'b0) begin failures++; $display("FAIL reset_borrow: got %0b expected 0", bus8.borrow); end
    checks++; if (bus8.busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %0b expected 0", bus8.busy); end
    checks++; if (bus8.done !== 1'b0)   begin failures++; $display("FAIL reset_done: got %0b expected 0", bus8.done); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (bus8.ovf !== 1'b0)    begin failures++; $display("FAIL reset_ovf: got %0b expected 0", bus8.ovf); end
`endif
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_directed();
    int ta[6] = '{200, 5, 60, 0, 255, 0};
    int tbv[6] = '{55, 10, 60, 1, 0, 255};
    int d, lat, bc;
    logic br, ov;
    for (int i = 0; i < 6; i++) begin
      run_op8(ta[i], tbv[i], d, br, ov, lat, bc);
      checks++; if (lat != 9) begin failures++; $display("FAIL dir_latency[%0d]: got %0d expected 9", i, lat); end
      checks++; if (bc != 8) begin failures++; $display("FAIL dir_busy_cycles[%0d]: got %0d expected 8", i, bc); end
      checks++; if (d != ref_diff(ta[i], tbv[i], 8)) begin failures++; $display("FAIL dir_diff[%0d]: got %0d expected %0d", i, d, ref_diff(ta[i], tbv[i], 8)); end
      checks++; if (br !== ref_borrow(ta[i], tbv[i])) begin failures++; $display("FAIL dir_borrow[%0d]: got %0b expected %0b", i, br, ref_borrow(ta[i], tbv[i])); end
    end
    // result of last op (0-255 = 1) must be held through idle cycles
    repeat (4) @(negedge clk);
    checks++; if (bus8.diff !== 8'd1) begin failures++; $display("FAIL hold_diff: got %0d expected 1", bus8.diff); end
    checks++; if (bus8.done !== 1'b0) begin failures++; $display("FAIL hold_done: got %0b expected 0", bus8.done); end
  endtask

  task automatic test_ignore_start();
    int dones = 0, late_busy = 0, lat = -1, dq = -1;
    logic bq = 1'bx;
    @(negedge clk);
    bus8.A = 8'd100; bus8.B = 8'd30; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus8.done) begin dones++; dq = int'(bus8.diff); bq = bus8.borrow; lat = n; end
      else if (dones > 0 && bus8.busy) late_busy++;
      bus8.start = (n == 3);
      if (n == 3) begin bus8.A = 8'd7; bus8.B = 8'd200; end
      @(negedge clk);
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL ign_done_count: got %0d expected 1", dones); end
    checks++; if (lat != 9) begin failures++; $display("FAIL ign_latency: got %0d expected 9", lat); end
    checks++; if (dq != 70) begin failures++; $display("FAIL ign_diff: got %0d expected 70", dq); end
    checks++; if (bq !== 1'b0) begin failures++; $display("FAIL ign_borrow: got %0b expected 0", bq); end
    checks++; if (late_busy != 0) begin failures++; $display("FAIL ign_queued: got %0d busy cycles expected 0", late_busy); end
  endtask

  task automatic test_back_to_back();
    int lat = -1;
    @(negedge clk);
    bus8.A = 8'd200; bus8.B = 8'd55; bus8.start = 1'b1;
    @(negedge clk);
    bus8.A = 8'd9; bus8.B = 8'd3;
    for (int n = 1; n < 40; n++) begin
      if (bus8.done) begin lat = n; break; end
      @(negedge clk);
    end
    checks++; if (lat != 9) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 9", lat); end
    checks++; if (bus8.diff !== 8'd145) begin failures++; $display("FAIL b2b_first_diff: got %0d expected 145", bus8.diff); end
    @(negedge clk);
    checks++; if (bus8.busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy: got %0b expected 1", bus8.busy); end
    checks++; if (bus8.diff !== 8'd145) begin failures++; $display("FAIL b2b_held_diff: got %0d expected 145", bus8.diff); end
    bus8.start = 1'b0;
    lat = -1;
    for (int n = 1; n < 40; n++) begin
      if (bus8.done) begin lat = n; break; end
      @(negedge clk);
    end
    checks++; if (lat != 9) begin failures++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
    checks++; if (bus8.diff !== 8'd6) begin failures++; $display("FAIL b2b_second_diff: got %0d expected 6", bus8.diff); end
    checks++; if (bus8.borrow !== 1'b0) begin failures++; $display("FAIL b2b_second_borrow: got %0b expected 0", bus8.borrow); end
  endtask

  task automatic test_reset_mid();
    int stray = 0, d, lat, bc;
    logic br, ov;
    @(negedge clk);
    bus8.A = 8'd50; bus8.B = 8'd20; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus8.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %0b expected 0", bus8.busy); end
    checks++; if (bus8.diff !== 8'd0) begin failures++; $display("FAIL rstmid_diff: got %0d expected 0", bus8.diff); end
    checks++; if (bus8.borrow !== 1'b0) begin failures++; $display("FAIL rstmid_borrow: got %0b expected 0", bus8.borrow); end
    checks++; if (bus8.done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %0b expected 0", bus8.done); end
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (bus8.done || bus8.busy) stray++;
      @(negedge clk);
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", stray); end
    run_op8(77, 33, d, br, ov, lat, bc);
    checks++; if (d != 44) begin failures++; $display("FAIL rstmid_fresh_diff: got %0d expected 44", d); end
    checks++; if (lat != 9) begin failures++; $display("FAIL rstmid_fresh_latency: got %0d expected 9", lat); end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int d, lat, bc;
    logic br, ov;
    run_op8(8'h80, 8'h01, d, br, ov, lat, bc);
    checks++; if (d != 8'h7F) begin failures++; $display("FAIL ovf_a_diff: got %0h expected 7f", d); end
    checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_a_flag: got %0b expected 1", ov); end
    run_op8(8'h10, 8'h01, d, br, ov, lat, bc);
    checks++; if (d != 8'h0F) begin failures++; $display("FAIL ovf_b_diff: got %0h expected f", d); end
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL ovf_b_flag: got %0b expected 0", ov); end
  endtask
`endif

  task automatic test_random8();
    int a, b, d, lat, bc;
    logic br, ov;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op8(a, b, d, br, ov, lat, bc);
      checks++; if (lat != 9) begin failures++; $display("FAIL rnd8_latency a=%0d b=%0d: got %0d expected 9", a, b, lat); end
      checks++; if (d != ref_diff(a, b, 8)) begin failures++; $display("FAIL rnd8_diff a=%0d b=%0d: got %0d expected %0d", a, b, d, ref_diff(a, b, 8)); end
      checks++; if (br !== ref_borrow(a, b)) begin failures++; $display("FAIL rnd8_borrow a=%0d b=%0d: got %0b expected %0b", a, b, br, ref_borrow(a, b)); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== ref_ovf(a, b, 8)) begin failures++; $display("FAIL rnd8_ovf a=%0d b=%0d: got %0b expected %0b", a, b, ov, ref_ovf(a, b, 8)); end
`endif
    end
  endtask

  task automatic test_random2();
    int a, b, lat;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      @(negedge clk);
      bus2.A = 2'(a); bus2.B = 2'(b); bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      lat = -1;
      for (int n = 1; n < 20; n++) begin
        if (bus2.done) begin lat = n; break; end
        @(negedge clk);
      end
      checks++; if (lat != 3) begin failures++; $display("FAIL rnd2_latency a=%0d b=%0d: got %0d expected 3", a, b, lat); end
      checks++; if (int'(bus2.diff) != ref_diff(a, b, 2)) begin failures++; $display("FAIL rnd2_diff a=%0d b=%0d: got %0d expected %0d", a, b, bus2.diff, ref_diff(a, b, 2)); end
      checks++; if (bus2.borrow !== ref_borrow(a, b)) begin failures++; $display("FAIL rnd2_borrow a=%0d b=%0d: got %0b expected %0b", a, b, bus2.borrow, ref_borrow(a, b)); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (bus2.ovf !== ref_ovf(a, b, 2)) begin failures++; $display("FAIL rnd2_ovf a=%0d b=%0d: got %0b expected %0b", a, b, bus2.ovf, ref_ovf(a, b, 2)); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random8();
    test_random2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
